// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
// The optional parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_tx_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int DEFAULT_DIV_W  = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        TX_START  = ST_START,
        TX_DATA   = ST_DATA,
        TX_PARITY = ST_PARITY,
        TX_STOP   = ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; bit_end is high while the count sits at zero.
module uart_baud_cnt
    import uart_tx_pkg::*;
#(
    parameter int W = DEFAULT_DIV_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         bit_end
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX bit engine: pops bytes from a show-ahead FIFO and sends 8-bit frames LSB first.
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit after the data.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      fifo_empty,
    input  logic [UART_DATA_BITS-1:0] fifo_data,
    output logic                      pop,
    input  logic [DIV_W-1:0]          divisor,
    input  logic                      stop2,
`ifdef UART_TX_PARITY_EN
    input  logic                      parity_odd,
`endif
    output logic                      txd,
    output logic                      busy,
    output logic                      frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_idx;
    logic                      stop_idx;
    logic [DIV_W-1:0]          div_q;
    logic                      stop2_q;
`ifdef UART_TX_PARITY_EN
    logic                      par_bit_q;
`endif

    logic             bit_end;
    logic             last_stop;
    logic             take;
    logic             load;
    logic [DIV_W-1:0] load_val;

    assign last_stop  = (state == TX_STOP) && bit_end && (!stop2_q || stop_idx);
    assign frame_done = last_stop;
    // Gated by rstn so a FIFO byte is never consumed while the engine is held in reset.
    assign take       = rstn && !fifo_empty && ((state == TX_IDLE) || last_stop);
    assign pop        = take;
    assign load       = take || (bit_end && (state != TX_IDLE) && !last_stop);
    assign load_val   = take ? divisor : div_q;

    uart_baud_cnt #(.W(DIV_W)) u_baud (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .load_val (load_val),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= TX_IDLE;
            txd       <= 1'b1;
            busy      <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            div_q     <= '0;
            stop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit_q <= 1'b0;
`endif
        end else if (take) begin
            state     <= TX_START;
            txd       <= 1'b0;
            busy      <= 1'b1;
            shift     <= fifo_data;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            div_q     <= divisor;
            stop2_q   <= stop2;
`ifdef UART_TX_PARITY_EN
            par_bit_q <= (^fifo_data) ^ parity_odd;
`endif
        end else if (bit_end) begin
            // txd is registered, so it is loaded with the level of the bit being entered.
            case (state)
                TX_START: begin
                    state <= TX_DATA;
                    txd   <= shift[0];
                end
                TX_DATA: begin
                    shift <= shift >> 1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state <= TX_PARITY;
                        txd   <= par_bit_q;
`else
                        state <= TX_STOP;
                        txd   <= 1'b1;
`endif
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        txd     <= shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    state <= TX_STOP;
                    txd   <= 1'b1;
                end
`endif
                TX_STOP: begin
                    if (last_stop) begin
                        state <= TX_IDLE;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
                    end else begin
                        stop_idx <= 1'b1;
                    end
                end
                TX_IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    state <= TX_IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues per-cycle txd/frame_done
// expectations, a negedge monitor pops and compares them whenever busy is high.
module tb_uart_tx_serializer;

    localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_data = 8'h00;
    logic             pop;
    logic [DIV_W-1:0] divisor = '0;
    logic             stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic             parity_odd = 1'b0;
`endif
    logic             txd;
    logic             busy;
    logic             frame_done;

    typedef struct packed {
        logic txd;
        logic fd;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pops = 0;
    int         run = 0;
    int         last_run = 0;
    logic       mon_en = 1'b0;
    logic       pop_s = 1'b0;
    logic       pop_prev = 1'b0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .pop        (pop),
        .divisor    (divisor),
        .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fifo_update();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic fifo_put(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_update();
    endtask

    // Expected line levels: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
    task automatic push_exp(input logic [7:0] b, input int d, input logic s2, input logic pb);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (PBITS == 1) bits.push_back(pb);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c <= d; c++) begin
                e.txd = bits[k];
                e.fd  = (k == bits.size() - 1) && (c == d);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (!(exp_q.size() == 0 && !busy && fifo_q.size() == 0) && n < budget);
        chk({name, "_done"}, (exp_q.size() == 0 && !busy) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    // FIFO model: a pop seen during a cycle removes the head right after that cycle's edge.
    initial begin
        logic [7:0] dummy;
        forever begin
            @(posedge clk);
            #1;
            if (pop_s && fifo_q.size() > 0) begin
                dummy = fifo_q.pop_front();
                pops++;
            end
            fifo_update();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        pop_s = pop;
        if (mon_en) begin
            if (pop && fifo_empty) begin
                checks++;
                errors++;
                $display("FAIL pop_when_empty actual=1 required=0 t=%0t", $time);
            end
            if (pop_prev) chk("busy_after_pop", busy, 1);
            if (busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy actual=busy required=idle t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("txd", txd, e.txd);
                    chk("frame_done", frame_done, e.fd);
                end
                run++;
            end else begin
                chk("idle_txd", txd, 1);
                chk("idle_frame_done", frame_done, 0);
                if (run > 0) begin
                    last_run = run;
                    run = 0;
                end
            end
        end
        pop_prev = pop;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pop", pop, 0);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Empty FIFO: line stays idle, no pops.
        repeat (50) @(posedge clk);
        chk("idle_pops", pops, 0);
        chk("idle_busy", busy, 0);

        // 0x55, D=3, one stop bit.
        @(posedge clk);
        #2;
        divisor = 16'd3;
        stop2   = 1'b0;
        p0      = pops;
        push_exp(8'h55, 3, 1'b0, 1'b0);
        fifo_put(8'h55);
        wait_done("t55", 300);
        chk("t55_pops", pops - p0, 1);
        chk("t55_len", last_run, (10 + PBITS) * 4);

        // Back-to-back 0xA5, 0x3C, D=0, two stop bits.
        @(posedge clk);
        #2;
        divisor = 16'd0;
        stop2   = 1'b1;
        p0      = pops;
        push_exp(8'hA5, 0, 1'b1, 1'b0);
        push_exp(8'h3C, 0, 1'b1, 1'b0);
        fifo_put(8'hA5);
        fifo_put(8'h3C);
        wait_done("b2b", 200);
        chk("b2b_pops", pops - p0, 2);
        chk("b2b_busy_len", last_run, (11 + PBITS) * 2);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: odd parity bit 0, even parity bit 1.
        @(posedge clk);
        #2;
        divisor    = 16'd1;
        stop2      = 1'b0;
        parity_odd = 1'b1;
        push_exp(8'h07, 1, 1'b0, 1'b0);
        fifo_put(8'h07);
        wait_done("par_odd", 200);
        chk("par_odd_len", last_run, 22);
        @(posedge clk);
        #2;
        parity_odd = 1'b0;
        push_exp(8'h07, 1, 1'b0, 1'b1);
        fifo_put(8'h07);
        wait_done("par_even", 200);
        chk("par_even_len", last_run, 22);
`endif

        // Reset during data bit 4 of 0xFF (D=1): start + bits 0..3 take 10 cycles.
        @(posedge clk);
        #2;
        divisor = 16'd1;
        stop2   = 1'b0;
        push_exp(8'hFF, 1, 1'b0, 1'b0);
        fifo_put(8'hFF);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_done", frame_done, 0);
        exp_q.delete();
        p0   = pops;
        rstn = 1'b1;
        repeat (30) @(posedge clk);
        chk("midrst_no_pop", pops - p0, 0);
        chk("midrst_idle", busy, 0);

        // Divisor 3 -> 7 mid-frame: only the following frame uses 8-cycle bits.
        @(posedge clk);
        #2;
        divisor = 16'd3;
        stop2   = 1'b0;
        p0      = pops;
        push_exp(8'h0F, 3, 1'b0, 1'b0);
        push_exp(8'hF0, 7, 1'b0, 1'b0);
        fifo_put(8'h0F);
        fifo_put(8'hF0);
        repeat (12) @(posedge clk);
        #2;
        divisor = 16'd7;
        wait_done("divchg", 400);
        chk("divchg_pops", pops - p0, 2);
        chk("divchg_len", last_run, (10 + PBITS) * 4 + (10 + PBITS) * 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
